// File: rtl/voice_allocator.sv
// voice_allocator: maps one decoded MIDI note stream onto NUM_VOICES
// synthesis pipelines (retrigger, free-first, release-steal, held-steal).
// Ports: clock_50_000_000 / reset_l (async, active-low) clock and reset;
//   note + note_ready      incoming event and its one-cycle strobe;
//   voice_idle             per-voice "envelope back at zero";
//   voice_note/voice_ready per-voice registered event and strobe;
//   voice_active           voice is held or releasing;
//   stolen                 last ON took a voice that was still held.
package MIDI;
  typedef enum logic {OFF = 1'b0, ON = 1'b1} status_t;
  typedef struct packed {
    logic [6:0] note_number;
    logic [6:0] velocity;
    status_t    status;
  } note_change_t;
endpackage

module voice_allocator
  import MIDI::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int AGE_WIDTH  = 8
) (
  input  logic                          clock_50_000_000,
  input  logic                          reset_l,
  input  note_change_t                  note,
  input  logic                          note_ready,
  input  logic [NUM_VOICES-1:0]         voice_idle,
  output note_change_t [NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0]         voice_ready,
  output logic [NUM_VOICES-1:0]         voice_active,
  output logic                          stolen
);
  typedef enum logic [1:0] {
    V_FREE = 2'd0,
    V_HELD = 2'd1,
    V_REL  = 2'd2
  } vstate_e;
  typedef logic [NUM_VOICES-1:0] vmask_t;
  typedef logic [AGE_WIDTH-1:0]  age_t;

  localparam vmask_t ONE     = vmask_t'(1);
  localparam age_t   AGE_ONE = age_t'(1);
  localparam age_t   AGE_MAX = '1;

  vstate_e st_q  [NUM_VOICES];
  vstate_e st_d  [NUM_VOICES];
  age_t    age_q [NUM_VOICES];
  age_t    age_d [NUM_VOICES];
  logic [6:0] nn_q [NUM_VOICES];
  logic [6:0] nn_d [NUM_VOICES];

  note_change_t [NUM_VOICES-1:0] vn_q, vn_d;
  vmask_t rdy_q, rdy_d, act_q, act_d;
  logic   stl_q, stl_d;

  logic is_on, is_off, steal;
  vmask_t held, rel, avail, match, match_lo;
  vmask_t old_rel, old_held, pick;
  age_t best_rel, best_held;
  note_change_t ev;

  function automatic vmask_t lowest(input vmask_t m);
    return m & (~m + ONE);
  endfunction

  // A velocity-0 ON behaves exactly like an OFF.
  assign is_on  = note_ready && note.status == ON &&
                  note.velocity != 7'd0;
  assign is_off = note_ready && !is_on;

  always_comb begin
    ev = note;
    ev.status = is_on ? ON : OFF;
  end

  always_comb begin
    held  = '0;
    rel   = '0;
    avail = '0;
    match = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      held[i]  = st_q[i] == V_HELD;
      rel[i]   = st_q[i] == V_REL;
      avail[i] = st_q[i] == V_FREE ||
                 (rel[i] && voice_idle[i]);
      match[i] = held[i] &&
                 nn_q[i] == note.note_number;
    end
  end

  // Oldest candidates; strict '>' keeps the lowest index on ties.
  always_comb begin
    old_rel   = '0;
    old_held  = '0;
    best_rel  = '0;
    best_held = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (rel[i] && !voice_idle[i] &&
          (old_rel == '0 || age_q[i] > best_rel)) begin
        old_rel  = ONE << i;
        best_rel = age_q[i];
      end
      if (held[i] &&
          (old_held == '0 || age_q[i] > best_held)) begin
        old_held  = ONE << i;
        best_held = age_q[i];
      end
    end
  end

  always_comb begin
    pick     = '0;
    steal    = 1'b0;
    match_lo = lowest(match);
    priority case (1'b1)
      (match != '0):   pick = match_lo;
      (avail != '0):   pick = lowest(avail);
      (old_rel != '0): pick = old_rel;
      default: begin
        pick  = old_held;
        steal = 1'b1;
      end
    endcase
  end

  always_comb begin
    rdy_d = '0;
    act_d = '0;
    stl_d = is_on && steal;
    vn_d  = vn_q;
    for (int i = 0; i < NUM_VOICES; i++) begin
      st_d[i]  = st_q[i];
      age_d[i] = age_q[i];
      nn_d[i]  = nn_q[i];
      if (rel[i] && voice_idle[i]) st_d[i] = V_FREE;
      if (is_on && pick[i]) begin
        st_d[i]  = V_HELD;
        age_d[i] = '0;
        nn_d[i]  = note.note_number;
        rdy_d[i] = 1'b1;
      end else if (is_on && st_q[i] != V_FREE &&
                   age_q[i] != AGE_MAX) begin
        age_d[i] = age_q[i] + AGE_ONE;
      end else if (is_off && match_lo[i]) begin
        st_d[i]  = V_REL;
        rdy_d[i] = 1'b1;
      end
      if (rdy_d[i]) vn_d[i] = ev;
      act_d[i] = st_d[i] != V_FREE;
    end
  end

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        st_q[i]  <= V_FREE;
        age_q[i] <= '0;
        nn_q[i]  <= '0;
      end
      vn_q  <= '0;
      rdy_q <= '0;
      act_q <= '0;
      stl_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        st_q[i]  <= st_d[i];
        age_q[i] <= age_d[i];
        nn_q[i]  <= nn_d[i];
      end
      vn_q  <= vn_d;
      rdy_q <= rdy_d;
      act_q <= act_d;
      stl_q <= stl_d;
    end
  end

  assign voice_note   = vn_q;
  assign voice_ready  = rdy_q;
  assign voice_active = act_q;
  assign stolen       = stl_q;
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: table vectors, directed corner cases and random
// traffic checked against a rule-level voice model.
module tb_voice_allocator;
  import MIDI::*;
  localparam int NV = 4;
  localparam int FREE = 0, HELD = 1, REL = 2;
  localparam int AMAX = 255;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  note_change_t note = '0;
  logic note_ready = 1'b0;
  logic [NV-1:0] idle = '0;
  note_change_t [NV-1:0] vnote;
  logic [NV-1:0] vready, vactive;
  logic stolen;

  int passed = 0;
  int total = 0;

  always #10 clk = ~clk;

  voice_allocator #(.NUM_VOICES(NV), .AGE_WIDTH(8)) dut (
    .clock_50_000_000(clk),
    .reset_l(rst_l),
    .note(note),
    .note_ready(note_ready),
    .voice_idle(idle),
    .voice_note(vnote),
    .voice_ready(vready),
    .voice_active(vactive),
    .stolen(stolen)
  );

  int mst [NV];
  int mage [NV];
  int mnn [NV];
  note_change_t [NV-1:0] m_note;
  logic [NV-1:0] m_ready, m_active;
  logic m_stolen;

  function automatic void chk(string name, logic [63:0] got,
                              logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endfunction

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) begin
      mst[v] = FREE;
      mage[v] = 0;
      mnn[v] = 0;
    end
    m_note = '0;
    m_ready = '0;
    m_active = '0;
    m_stolen = 1'b0;
  endfunction

  function automatic void model_step(note_change_t e, logic rdy,
                                     logic [NV-1:0] idl);
    bit on, off;
    int tgt, best;
    note_change_t out;
    on = rdy && e.status == ON && e.velocity != 0;
    off = rdy && !on;
    tgt = -1;
    m_ready = '0;
    m_stolen = 1'b0;
    if (on) begin
      for (int v = 0; v < NV; v++)
        if (tgt < 0 && mst[v] == HELD && mnn[v] == int'(e.note_number))
          tgt = v;
      for (int v = 0; v < NV; v++)
        if (tgt < 0 && (mst[v] == FREE || (mst[v] == REL && idl[v])))
          tgt = v;
      if (tgt < 0) begin
        best = -1;
        for (int v = 0; v < NV; v++)
          if (mst[v] == REL && mage[v] > best) begin
            best = mage[v];
            tgt = v;
          end
      end
      if (tgt < 0) begin
        best = -1;
        for (int v = 0; v < NV; v++)
          if (mst[v] == HELD && mage[v] > best) begin
            best = mage[v];
            tgt = v;
          end
        m_stolen = 1'b1;
      end
      for (int v = 0; v < NV; v++)
        if (v != tgt && mst[v] != FREE && mage[v] < AMAX) mage[v]++;
    end else if (off) begin
      for (int v = 0; v < NV; v++)
        if (tgt < 0 && mst[v] == HELD && mnn[v] == int'(e.note_number))
          tgt = v;
    end
    for (int v = 0; v < NV; v++)
      if (mst[v] == REL && idl[v] && !(on && v == tgt)) mst[v] = FREE;
    if (tgt >= 0) begin
      out = e;
      out.status = on ? ON : OFF;
      m_note[tgt] = out;
      m_ready[tgt] = 1'b1;
      if (on) begin
        mst[tgt] = HELD;
        mage[tgt] = 0;
        mnn[tgt] = int'(e.note_number);
      end else begin
        mst[tgt] = REL;
      end
    end
    for (int v = 0; v < NV; v++) m_active[v] = mst[v] != FREE;
  endfunction

  function automatic note_change_t mk(bit on, int nn, int vel);
    note_change_t n;
    n.note_number = 7'(nn);
    n.velocity = 7'(vel);
    n.status = on ? ON : OFF;
    return n;
  endfunction

  task automatic cycle(input note_change_t e, input logic rdy,
                       input logic [NV-1:0] idl, input string tag);
    note = e;
    note_ready = rdy;
    idle = idl;
    model_step(e, rdy, idl);
    @(posedge clk);
    #1;
    chk({tag, " ready"}, 64'(vready), 64'(m_ready));
    chk({tag, " stolen"}, 64'(stolen), 64'(m_stolen));
    chk({tag, " active"}, 64'(vactive), 64'(m_active));
    chk({tag, " vnote"}, 64'(vnote), 64'(m_note));
    note_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    note_ready = 1'b0;
    idle = '0;
    note = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit rst;
    bit rdy;
    bit on;
    int nn;
    int vel;
    logic [NV-1:0] idl;
    logic [NV-1:0] er;
    bit es;
    logic [NV-1:0] ea;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit rst, bit rdy, bit on, int nn, int vel,
                              logic [NV-1:0] idl, logic [NV-1:0] er,
                              bit es, logic [NV-1:0] ea);
    vec_t t;
    t.rst = rst; t.rdy = rdy; t.on = on; t.nn = nn; t.vel = vel;
    t.idl = idl; t.er = er; t.es = es; t.ea = ea;
    tbl.push_back(t);
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    string tg;
    // basic allocation, fill and steal
    add(1, 1, 1, 60, 100, 4'b0000, 4'b0001, 0, 4'b0001);
    add(0, 1, 0, 60,   0, 4'b0000, 4'b0001, 0, 4'b0001);
    add(0, 0, 0,  0,   0, 4'b0000, 4'b0000, 0, 4'b0001);
    add(0, 0, 0,  0,   0, 4'b0001, 4'b0000, 0, 4'b0000);
    add(0, 1, 1, 60, 100, 4'b0000, 4'b0001, 0, 4'b0001);
    add(0, 1, 1, 62, 100, 4'b0000, 4'b0010, 0, 4'b0011);
    add(0, 1, 1, 64, 100, 4'b0000, 4'b0100, 0, 4'b0111);
    add(0, 1, 1, 67, 100, 4'b0000, 4'b1000, 0, 4'b1111);
    add(0, 1, 1, 69, 100, 4'b0000, 4'b0001, 1, 4'b1111);
    add(0, 1, 1, 71, 100, 4'b0000, 4'b0010, 1, 4'b1111);
    // releasing beats held
    add(1, 1, 1, 60, 100, 4'b0000, 4'b0001, 0, 4'b0001);
    add(0, 1, 1, 62, 100, 4'b0000, 4'b0010, 0, 4'b0011);
    add(0, 1, 1, 64, 100, 4'b0000, 4'b0100, 0, 4'b0111);
    add(0, 1, 1, 67, 100, 4'b0000, 4'b1000, 0, 4'b1111);
    add(0, 1, 0, 62,  64, 4'b0000, 4'b0010, 0, 4'b1111);
    add(0, 1, 1, 72, 100, 4'b0000, 4'b0010, 0, 4'b1111);
    // retrigger, velocity 0, unmatched OFF
    add(1, 1, 1, 60,  50, 4'b0000, 4'b0001, 0, 4'b0001);
    add(0, 1, 1, 60,  90, 4'b0000, 4'b0001, 0, 4'b0001);
    add(0, 1, 1, 60,   0, 4'b0000, 4'b0001, 0, 4'b0001);
    add(0, 1, 0, 61,   0, 4'b0000, 4'b0000, 0, 4'b0001);
    // back-to-back and same-cycle release completion
    add(1, 1, 1, 60, 100, 4'b0000, 4'b0001, 0, 4'b0001);
    add(0, 1, 1, 64, 100, 4'b0000, 4'b0010, 0, 4'b0011);
    add(0, 1, 1, 65, 100, 4'b0000, 4'b0100, 0, 4'b0111);
    add(0, 1, 1, 67, 100, 4'b0000, 4'b1000, 0, 4'b1111);
    add(0, 1, 0, 65,   0, 4'b0000, 4'b0100, 0, 4'b1111);
    add(0, 1, 1, 70, 100, 4'b0100, 4'b0100, 0, 4'b1111);

    do_reset();
    chk("reset ready", 64'(vready), 64'(0));
    chk("reset active", 64'(vactive), 64'(0));
    chk("reset stolen", 64'(stolen), 64'(0));
    chk("reset vnote", 64'(vnote), 64'(0));

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      tg = $sformatf("vec%0d", i);
      cycle(mk(tbl[i].on, tbl[i].nn, tbl[i].vel), tbl[i].rdy,
            tbl[i].idl, tg);
      chk({tg, " tbl ready"}, 64'(vready), 64'(tbl[i].er));
      chk({tg, " tbl stolen"}, 64'(stolen), 64'(tbl[i].es));
      chk({tg, " tbl active"}, 64'(vactive), 64'(tbl[i].ea));
    end

    // age saturation: voice 0 must stay oldest after 255+ events
    do_reset();
    cycle(mk(1, 60, 100), 1'b1, '0, "sat on60");
    for (int k = 0; k < 255; k++) begin
      model_step(mk(1, 61, 100), 1'b1, '0);
      note = mk(1, 61, 100);
      note_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    cycle(mk(1, 62, 100), 1'b1, '0, "sat on62");
    cycle(mk(1, 63, 100), 1'b1, '0, "sat on63");
    cycle(mk(1, 64, 100), 1'b1, '0, "sat steal");
    chk("sat steal target", 64'(vready), 64'(4'b0001));
    chk("sat steal flag", 64'(stolen), 64'(1));

    // reset asserted during an event strobe
    do_reset();
    cycle(mk(1, 60, 100), 1'b1, '0, "mid on60");
    cycle(mk(1, 62, 100), 1'b1, '0, "mid on62");
    note = mk(1, 64, 100);
    note_ready = 1'b1;
    #4 rst_l = 1'b0;
    #1;
    chk("midrst ready", 64'(vready), 64'(0));
    chk("midrst active", 64'(vactive), 64'(0));
    chk("midrst vnote", 64'(vnote), 64'(0));
    model_reset();
    @(posedge clk);
    #3 note_ready = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst ready", 64'(vready), 64'(0));
    chk("postrst active", 64'(vactive), 64'(0));
    cycle(mk(1, 70, 100), 1'b1, '0, "postrst on70");
    chk("postrst target", 64'(vready), 64'(4'b0001));

    // random traffic against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      note_change_t e;
      logic r;
      e.note_number = 7'(60 + $urandom_range(0, 4));
      e.velocity = ($urandom_range(0, 4) == 0) ? 7'd0
                 : 7'($urandom_range(1, 127));
      e.status = ($urandom_range(0, 9) < 6) ? ON : OFF;
      r = $urandom_range(0, 9) < 7;
      cycle(e, r, NV'($urandom), $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice scheduler between the MIDI decoder and an array of `NUM_VOICES` identical synthesis pipelines. It takes the single decoded note-change stream and assigns each note to one pipeline. It tracks per-voice hold/release state and allocation age, and steals the oldest voice when all voices are busy. Each pipeline receives its own registered `note_change_t` and a one-cycle ready strobe, so its oscillator-clear and envelope on/off triggers fire exactly once per event.

## Interface
- `NUM_VOICES`, default 4: number of pipelines served; range 2..16.
- `AGE_WIDTH`, default 8: width of each saturating per-voice age counter.

- `clock_50_000_000`  in  1: system clock; every register is clocked on its rising edge.
- `reset_l`  in  1: asynchronous, active-low reset.
- `note`  in  `MIDI::note_change_t`: decoded event with `note_number`, `velocity`, `status` (ON/OFF); valid only when `note_ready`=1.
- `note_ready`  in  1: one-cycle event strobe; may assert on consecutive cycles.
- `voice_idle`  in  `NUM_VOICES`: per-pipeline flag; 1 = envelope has returned to zero.
- `voice_note`  out  `NUM_VOICES` x `note_change_t`: per-voice registered event; holds its value between events.
- `voice_ready`  out  `NUM_VOICES`: one-cycle strobe qualifying `voice_note[v]`.
- `voice_active`  out  `NUM_VOICES`: 1 = voice is HELD or RELEASING.
- `stolen`  out  1: one-cycle strobe; the last ON event took a voice that was HELD.

## Operation
- Each voice has a state and an age. States are FREE, HELD and RELEASING; each voice also stores its `note_number`.
- A voice is *available* when it is FREE, or when it is RELEASING with `voice_idle[v]`=1 in the current cycle.
- **ON event with velocity > 0.** The first matching rule selects the target voice:
  1. A HELD voice with the same `note_number` (retrigger; lowest index wins).
  2. The lowest-index available voice.
  3. The RELEASING voice with the largest age.
  4. The HELD voice with the largest age; `stolen` pulses.
- Age ties in rules 3 and 4 go to the lowest index.
- Effect of an ON event on the target voice:
  - State becomes HELD, its note is stored, and its age is cleared to 0.
  - Every other non-FREE voice increments its age, saturating at 2^`AGE_WIDTH`-1.
  - `voice_note[target]` is loaded with the ON event and `voice_ready[target]` pulses.
- **ON event with velocity = 0.** Treated exactly as an OFF event for the same `note_number`.
- **OFF event.**
  - Find the lowest-index HELD voice whose `note_number` matches.
  - That voice goes to RELEASING; `voice_note` is loaded with the OFF event and `voice_ready` pulses.
  - With no match, the event is dropped and no output changes.
- **Release completion.** A RELEASING voice with `voice_idle`=1 becomes FREE, unless it is the target of an ON event in the same cycle.
- `voice_idle` is ignored for FREE and HELD voices.
- A retrigger (rule 1) or steal (rule 4) issues only an ON to the target. No OFF is sent first; the pipeline's clear-on-ON restarts the voice.
- The `status` field of `voice_note` is copied from the input, except that a velocity-0 ON is re-encoded as OFF.

## Timing
- Reset (asynchronous assert, synchronous release to the clock):
  - All voices FREE, ages 0, stored notes 0.
  - `voice_note` = '0, `voice_ready` = 0, `voice_active` = 0, `stolen` = 0.
- Latency: one cycle. An event sampled at edge N drives `voice_ready`, `voice_note` and `stolen` from edge N+1, for exactly one cycle.
- Throughput: one event per cycle, with no backpressure.
  - Back-to-back events each see the state already updated by the previous event.
  - Two ON events in consecutive cycles must land on different voices whenever a second voice is available.
- `voice_active` is registered and reflects state after edge N+1.
- Reset asserted mid-event: any pending strobe is discarded and nothing is emitted after release.
- Voice selection is combinational from current state and `voice_idle`, and must fit within one 20 ns cycle for `NUM_VOICES`=16.

## Test plan
- **Basic allocation.** Reset, then ON note 60 vel 100 → `voice_ready`=0001 one cycle later, `voice_note[0]`={60,100,ON}. Then OFF note 60 → `voice_ready`=0001 with OFF, and `voice_active[0]` stays 1 until `voice_idle[0]`=1, after which it clears.
- **Fill and steal.** ON notes 60, 62, 64, 67 land on voices 0..3. ON note 69 → voice 0 (oldest HELD), `stolen`=1. Then ON 71 → voice 1, `stolen`=1.
- **Release preference.** Four voices HELD; OFF 62 (voice 1); ON 72 with `voice_idle`=0 → voice 1 (RELEASING beats HELD), `stolen`=0.
- **Retrigger and velocity 0.**
  - ON 60 vel 50, then ON 60 vel 90 → same voice 0, second event carries vel 90, no other voice used.
  - ON 60 vel 0 → OFF on voice 0.
  - OFF 61 with no match → no strobe.
- **Back-to-back and simultaneity.**
  - ON 60 and ON 64 on consecutive cycles → voices 0 and 1.
  - Voice 2 RELEASING with `voice_idle[2]`=1 in the same cycle as an ON, with voices 0, 1, 3 HELD → voice 2 chosen, `stolen`=0.
- **Async reset mid-stream.** Assert `reset_l`=0 during a `note_ready` cycle → all outputs 0 immediately. No strobe after release; the next ON goes to voice 0.
